// File: rtl/tx_link_ctrl.sv
// tx_link_ctrl: transmit link bring-up FSM (CGS -> WAIT_LMFC -> ILA -> DATA) with LMFC octet/frame counters.
// Latency: o_sel/o_data_rdy follow the state register by one cycle; o_ila_start is registered at the WAIT_LMFC->ILA edge.
// Backpressure: none; SYNC~ (i_sync_n) low is the only throttle and drops the link back to CGS.
//
// Ports:
//   clk, rst_n               character clock, async active-low reset
//   i_sync_n                 SYNC~ from the receiver (low = request code group sync)
//   i_F, i_K                 octets per frame - 1, frames per multiframe - 1 (change only in CGS)
//   i_lmfc_align             one-cycle pulse, restarts the LMFC counters at 0 on the next cycle
//   i_ila_end / o_ila_start  handshake with the ILA generator
//   o_no_frame_de_assertion  frame index captured when SYNC~ de-asserts in CGS
//   o_sel                    lane mux select: 0 K28.5, 1 ILA, 2 user data
//   o_data_rdy, o_lmfc       user data phase flag, first octet of multiframe
//   o_state                  FSM state code
//   o_sync_err_cnt           SYNC~ error-report pulse count (0 unless SYNC_ERR_REPORT_EN)
//
// Optional feature macro: SYNC_ERR_REPORT_EN. When defined, short SYNC~ low pulses in DATA are
// treated as error reports and counted; only a long low run forces re-sync.

module tx_link_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sync_n,
  input  logic [7:0] i_F,
  input  logic [4:0] i_K,
  input  logic       i_lmfc_align,
  input  logic       i_ila_end,
  output logic       o_ila_start,
  output logic [4:0] o_no_frame_de_assertion,
  output logic [1:0] o_sel,
  output logic       o_data_rdy,
  output logic       o_lmfc,
  output logic [1:0] o_state,
  output logic [7:0] o_sync_err_cnt
);

  typedef enum logic [1:0] {
    ST_CGS       = 2'd0,
    ST_WAIT_LMFC = 2'd1,
    ST_ILA       = 2'd2,
    ST_DATA      = 2'd3
  } state_t;

  localparam logic [1:0] SEL_CGS  = 2'd0;
  localparam logic [1:0] SEL_ILA  = 2'd1;
  localparam logic [1:0] SEL_DATA = 2'd2;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] oc;
  logic [4:0] fc;
  logic       oc_wrap;
  logic       mf_end;
  logic       ila_start_nxt;

  // ---------------------------------------------------------------------------
  // LMFC counters: oc counts octets in a frame, fc counts frames in a multiframe.
  // ---------------------------------------------------------------------------
  assign oc_wrap = (oc == i_F);
  assign mf_end  = oc_wrap && (fc == i_K);   // last octet of the multiframe

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oc <= '0;
      fc <= '0;
    end else if (i_lmfc_align) begin
      oc <= '0;
      fc <= '0;
    end else if (oc_wrap) begin
      oc <= '0;
      fc <= (fc == i_K) ? 5'd0 : fc + 5'd1;
    end else begin
      oc <= oc + 8'd1;
    end
  end

  assign o_lmfc  = (oc == 8'd0) && (fc == 5'd0);
  assign o_state = state;

`ifdef SYNC_ERR_REPORT_EN
  // ---------------------------------------------------------------------------
  // SYNC~ error reporting: low_cnt holds the number of consecutive low cycles
  // already seen in DATA. A run reaching 5*(F+1)+9 is a real re-sync request;
  // a shorter run that ends is an error report.
  // ---------------------------------------------------------------------------
  logic [10:0] low_cnt;
  logic [10:0] low_thresh;
  logic        low_limit;
  logic        err_inc;
  logic [7:0]  err_cnt;

  // 5*(F+1)+9 = 5*F + 14; max 1289, fits 11 bits.
  assign low_thresh = ({3'b000, i_F} << 2) + {3'b000, i_F} + 11'd14;
  assign low_limit  = (state == ST_DATA) && !i_sync_n && ((low_cnt + 11'd1) == low_thresh);
  assign err_inc    = (state == ST_DATA) && i_sync_n && (low_cnt != 11'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if ((state == ST_DATA) && !i_sync_n && !low_limit) begin
        low_cnt <= low_cnt + 11'd1;
      end else begin
        low_cnt <= '0;
      end
      if (err_inc && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  assign o_sync_err_cnt = err_cnt;
`else
  assign o_sync_err_cnt = 8'd0;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_CGS;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    ila_start_nxt = 1'b0;
    case (state)
      ST_CGS: begin
        if (i_sync_n) begin
          state_nxt = ST_WAIT_LMFC;
        end
      end
      ST_WAIT_LMFC: begin
        if (!i_sync_n) begin
          state_nxt = ST_CGS;
        end else if (mf_end && !i_lmfc_align) begin
          // An align pulse this cycle re-phases the LMFC, so this is no longer
          // a multiframe boundary; wait for the re-phased one.
          state_nxt     = ST_ILA;
          ila_start_nxt = 1'b1;
        end
      end
      ST_ILA: begin
        if (!i_sync_n) begin
          state_nxt = ST_CGS;
        end else if (i_ila_end) begin
          state_nxt = ST_DATA;
        end
      end
      default: begin
`ifdef SYNC_ERR_REPORT_EN
        if (low_limit) begin
          state_nxt = ST_CGS;
        end
`else
        if (!i_sync_n) begin
          state_nxt = ST_CGS;
        end
`endif
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ila_start <= 1'b0;
      o_data_rdy  <= 1'b0;
      o_sel       <= SEL_CGS;
    end else begin
      o_ila_start <= ila_start_nxt;
      o_data_rdy  <= (state == ST_DATA);
      case (state)
        ST_ILA:  o_sel <= SEL_ILA;
        ST_DATA: o_sel <= SEL_DATA;
        default: o_sel <= SEL_CGS;
      endcase
    end
  end

  // Frame index at the moment SYNC~ de-asserts, for deterministic-latency diagnostics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_no_frame_de_assertion <= '0;
    end else if ((state == ST_CGS) && i_sync_n) begin
      o_no_frame_de_assertion <= fc;
    end
  end

endmodule
